// File: rtl/adder_pipelined_param.sv
// rtl/adder_pipelined_param.sv - skewed-pipeline chunked ripple adder/subtractor with valid/ready stream handshake
module adder_pipelined_param #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Per-stage state: operands travel with the bundle (b already inverted for
    // subtraction), s accumulates finished low chunks, c is the ripple carry.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;

    logic              stall;
    logic [WIDTH-1:0]  src_a, src_b, src_s;
    logic              src_c;
    logic [CHUNK:0]    chunk_sum;
    int                prev;

    // A held result freezes the whole pipeline; accept whenever it moves.
    assign stall     = v_q[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Next state of every stage: stage k adds chunk k of its incoming operands.
    always_comb begin
        ovf_d     = 1'b0;
        src_a     = '0;
        src_b     = '0;
        src_s     = '0;
        src_c     = 1'b0;
        chunk_sum = '0;
        prev      = 0;
        for (int k = 0; k < STAGES; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                src_a  = a;
                src_b  = sub ? ~b : b;
                src_s  = '0;
                src_c  = sub | c;
                v_d[k] = in_valid;
            end else begin
                src_a  = a_q[prev];
                src_b  = b_q[prev];
                src_s  = s_q[prev];
                src_c  = c_q[prev];
                v_d[k] = v_q[prev];
            end
            chunk_sum = {1'b0, src_a[k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c};
            a_d[k] = src_a;
            b_d[k] = src_b;
            s_d[k] = src_s;
            s_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            c_d[k] = chunk_sum[CHUNK];
            // Sign rule: like-signed operands giving an opposite-signed sum,
            // equivalent to carry-into-MSB xor carry-out.
            if (k == STAGES - 1) begin
                ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                        (chunk_sum[CHUNK-1] != src_a[WIDTH-1]);
            end
        end
    end

    // Stage registers: cleared by reset, frozen during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_adder_pipelined_param.sv
// tb/tb_adder_pipelined_param.sv - randomized and directed bench against an integer-arithmetic model
module tb_adder_pipelined_param;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, in_ready, c = 1'b0, sub = 1'b0;
    logic         out_valid, out_ready = 1'b1, cout, ovf;
    logic [W-1:0] a = '0, b = '0, s;

    logic         in_valid16 = 1'b0, in_ready16, c16 = 1'b0, sub16 = 1'b0;
    logic         out_valid16, cout16, ovf16;
    logic [15:0]  a16 = '0, b16 = '0, s16;

    adder_pipelined_param #(.WIDTH(8), .CHUNK(2)) uut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    adder_pipelined_param #(.WIDTH(16), .CHUNK(4)) uut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .c(c16), .sub(sub16), .out_valid(out_valid16),
        .out_ready(1'b1), .s(s16), .cout(cout16), .ovf(ovf16)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, s} from plain unsigned and signed integer arithmetic.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic cv, input logic subv);
        longint mask, half, ua, ub, full, sa, sb, r;
        logic   o;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        full = subv ? ua + (mask - ub) + 1 : ua + ub + (cv ? 1 : 0);
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        r    = subv ? sa - sb : sa + sb + (cv ? 1 : 0);
        o    = (r > half - 1) || (r < -half);
        return {o, full[w], 32'(full & mask)};
    endfunction

    // Scoreboard: log accepted bundles, match consumed results, check stall hold.
    logic         stalled_prev = 1'b0;
    logic [W-1:0] s_prev = '0;
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst) begin
            exp_q.delete();
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("hold_s", 32'(s), 32'(s_prev));
                check("hold_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("sb_s", 32'(s), 32'(e[W-1:0]));
                check("sb_cout", 32'(cout), 32'(e[32]));
                check("sb_ovf", 32'(ovf), 32'(e[33]));
            end
            if (in_valid && in_ready) exp_q.push_back(model(W, 32'(a), 32'(b), c, sub));
            stalled_prev = out_valid && !out_ready;
            s_prev       = s;
        end
    end

    task automatic directed(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input logic subv, input logic [7:0] es,
                            input logic ec, input logic eo);
        int n;
        a = av; b = bv; c = cv; sub = subv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
    endtask

    task automatic directed16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                              input logic subv, input logic [15:0] es, input logic ec);
        int n;
        a16 = av; b16 = bv; c16 = 1'b0; sub16 = subv; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        n = 1;
        while (!out_valid16 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_s"}, 32'(s16), 32'(es));
        check({tag, "_cout"}, 32'(cout16), 32'(ec));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] pick [5];
        logic       acc;
        int         n;

        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill the output, stall it, then reset asynchronously mid-cycle.
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_s", 32'(s), 32'd0);
        check("async_rst_cout", 32'(cout), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;

        directed("ripple", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("ovf_add", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("sub_neg", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        directed("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Streaming 1..6 with a 3-cycle stall while result 3 is shown.
        for (int cyc = 1; cyc <= 13; cyc++) begin
            int e;
            e = cyc - 1;
            if (e >= 4) begin
                if (e <= 6)      check("stream_s", 32'(s), 32'(2 * (e - 3)));
                else if (e <= 9) check("stream_hold_s", 32'(s), 32'd6);
                else             check("stream_s", 32'(s), 32'(2 * (e - 6)));
                check("stream_valid", 32'(out_valid), 32'd1);
            end
            in_valid  = (cyc <= 6);
            a = 8'(cyc); b = 8'(cyc); c = 1'b0; sub = 1'b0;
            out_ready = !(cyc >= 7 && cyc <= 9);
            #1;
            if (!out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        // Reset with three bundles in flight: none may surface.
        for (int i = 0; i < 3; i++) begin
            a = 8'(8'h10 + i); b = 8'h22; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("flushed_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        directed("post_rst", 8'h33, 8'h44, 1'b1, 1'b0, 8'h78, 1'b0, 1'b0);

        // Random traffic with random backpressure; producer holds unaccepted bundles.
        pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h7F; pick[3] = 8'h80; pick[4] = 8'h01;
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a   = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
                b   = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
                c   = 1'($urandom);
                sub = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        directed16("w16_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        directed16("w16_sub", 16'h1234, 16'h0F0F, 1'b1, 16'h0325, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
